// File: rtl/rom16x1_rr_arb.sv
// rom16x1_rr_arb: round-robin arbiter sharing one ROM16X1A between 4 requesters.
// Two-stage pipeline: issue (grant + ROM address) then capture (DO/DOV/DOID).
// Optional macro ROM_SCAN_EN adds a background scan of the ROM into SIG and
// compares it against INITVAL (SCAN_DONE/SCAN_ERR).
module rom16x1_rr_arb #(
  parameter logic [15:0] INITVAL = 16'h0000
) (
  input  logic        CK,
  input  logic        RST,
  input  logic [3:0]  REQ,
  input  logic [15:0] ADDR,
  output logic [3:0]  GNT,
  output logic [3:0]  ROM_AD,
  input  logic        ROM_DO,
  output logic        DO,
  output logic        DOV,
  output logic [1:0]  DOID,
  output logic        BUSY
`ifdef ROM_SCAN_EN
  ,
  output logic        SCAN_DONE,
  output logic        SCAN_ERR,
  output logic [15:0] SIG
`endif
);

  logic [1:0] ptr;      // round-robin search start
  logic [1:0] gnt_id;   // index of the requester granted in the issue stage
  logic       found;
  logic [1:0] win;
  logic [1:0] idx;

  // Winner search from ptr upward; a requester granted last cycle is masked.
  // An X on REQ makes the if-condition false, so it counts as no request.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    idx   = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + k[1:0];
      if (!found && REQ[idx] && !GNT[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

`ifdef ROM_SCAN_EN
  logic [3:0] cnt;        // next ROM address to scan
  logic [3:0] scan_idx;   // address of the scan slot in flight
  logic       scan_slot;  // a scan slot was issued last edge
  logic       scan_go;

  // Scan only while unfinished, and stop issuing once bit 15 is in flight.
  assign scan_go = !SCAN_DONE && !(scan_slot && scan_idx == 4'hF) && !found;
`endif

  // Issue stage: register grant, ROM address and busy flag.
  always_ff @(posedge CK) begin
    if (RST) begin
      GNT    <= 4'b0000;
      ROM_AD <= 4'h0;
      BUSY   <= 1'b0;
      ptr    <= 2'd0;
      gnt_id <= 2'd0;
    end else if (found) begin
      GNT    <= 4'b0001 << win;
      ROM_AD <= ADDR[{win, 2'b00} +: 4];
      BUSY   <= 1'b1;
      ptr    <= win + 2'd1;
      gnt_id <= win;
`ifdef ROM_SCAN_EN
    end else if (scan_go) begin
      GNT    <= 4'b0000;
      ROM_AD <= cnt;
      BUSY   <= 1'b1;
`endif
    end else begin
      GNT    <= 4'b0000;
      BUSY   <= 1'b0;
    end
  end

  // Capture stage: a request slot issued last edge returns its ROM bit.
  always_ff @(posedge CK) begin
    if (RST) begin
      DO   <= 1'b0;
      DOV  <= 1'b0;
      DOID <= 2'd0;
    end else if (|GNT) begin
      DO   <= ROM_DO;
      DOV  <= 1'b1;
      DOID <= gnt_id;
    end else begin
      DOV  <= 1'b0;
    end
  end

`ifdef ROM_SCAN_EN
  // Scanner: advance on idle slots, fold captured bits into SIG, judge at bit 15.
  always_ff @(posedge CK) begin
    if (RST) begin
      cnt       <= 4'h0;
      scan_idx  <= 4'h0;
      scan_slot <= 1'b0;
      SIG       <= 16'h0000;
      SCAN_DONE <= 1'b0;
      SCAN_ERR  <= 1'b0;
    end else begin
      scan_slot <= scan_go;
      if (scan_go) begin
        cnt      <= cnt + 4'h1;
        scan_idx <= cnt;
      end
      if (scan_slot) begin
        SIG[scan_idx] <= ROM_DO;
        if (scan_idx == 4'hF) begin
          SCAN_DONE <= 1'b1;
          SCAN_ERR  <= ({ROM_DO, SIG[14:0]} != INITVAL);
        end
      end
    end
  end
`else
  // Without the scanner INITVAL is informational only.
  if (INITVAL == 16'h0000) begin : g_initval_default
  end
`endif

endmodule
